line_xfer_sequencer: RTL and testbench
======================================

LINE_XFER_SEQUENCER -- requirements
Module: line_xfer_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 32, meaning cache line size in bytes (power of two, 8..64); BEATS = BLOCK_SIZE/4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  line transfer request from the arbiter.
REQ-005 SHALL have port req_write  input  1  1 = line write-back, 0 = line fill.
REQ-006 SHALL have port req_addr  input  32  byte address inside the target line.
REQ-007 SHALL have port req_wdata  input  BLOCK_SIZE*8  write-back line, word k at bits [32k+31:32k].
REQ-008 SHALL have port req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  BLOCK_SIZE*8  assembled fill line, same word layout as req_wdata.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port addr  output  32  beat address to the AHB adapter.
REQ-013 SHALL have port write  output  1  beat direction to the adapter.
REQ-014 SHALL have port wdata  output  32  beat write data.
REQ-015 SHALL have port transfer  output  3  bit0 beat valid, bit1 first beat, bit2 last beat.
REQ-016 SHALL have port rdata  input  32  beat read data from the adapter.
REQ-017 SHALL have port ready  input  1  current beat completes in this cycle.

Function
REQ-018 SHALL implement states IDLE, XFER, DONE; IDLE->XFER on accept, XFER->DONE when the last beat completes, DONE->IDLE unconditionally.
REQ-019 SHALL latch req_write, the line base (req_addr with low log2(BLOCK_SIZE) bits cleared) and req_wdata on accept; later input changes are ignored.
REQ-020 SHALL, in XFER, drive addr = base + 4*widx, write = latched direction, wdata = latched word widx, transfer[0]=1, transfer[1]=(beat count 0), transfer[2]=(beat count BEATS-1).
REQ-021 SHALL hold all beat outputs stable while ready=0; the beat count advances only on ready=1 in XFER.
REQ-022 SHALL, for a fill, capture rdata into rsp_rdata word widx in the same cycle ready=1.
REQ-023 SHALL pulse rsp_valid for exactly the one cycle in DONE; rsp_rdata holds its value until the next fill accept.
REQ-024 SHALL give latency accept-to-rsp_valid of BEATS+1 cycles with ready held high; each ready-low cycle adds one.
REQ-025 SHALL compute widx modulo BEATS (wrap within the line, never cross into the next line).
REQ-026 SHALL drive addr, write, wdata, transfer to zero outside XFER; ready outside XFER is ignored.
REQ-027 SHALL accept no new request during DONE; a req_valid held across DONE is accepted in the following IDLE cycle.

Reset
REQ-028 SHALL, on rst, force IDLE, clear the beat count and rsp_rdata, and drive req_ready=0, rsp_valid=0, busy=0, addr/write/wdata/transfer=0 in the reset cycle.
REQ-029 SHALL abandon an in-flight transfer on rst with no rsp_valid; req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL honour macro LXS_CRITICAL_WORD_FIRST_EN: when defined, fills start at widx = req_addr[log2(BLOCK_SIZE)-1:2] and wrap; when undefined, and always for write-backs, widx starts at 0.

Structure
REQ-031 SHALL take the state encoding, transfer bit positions (TR_VALID=0, TR_FIRST=1, TR_LAST=2) and the BEATS derivation from shared package lxs_pkg.
REQ-032 SHALL place beat counting and widx/address generation in one sub-module, lxs_beat_gen.

Verification
REQ-033 SHALL cover fill at 0x0000_1004, BLOCK_SIZE=32, ready always 1, rdata=0xA0+beat -> 8 beats from 0x1000 (0x1004 first with the macro), rsp_valid 9 cycles after accept, word k = rdata at 0x1000+4k.
REQ-034 SHALL cover write-back at 0x0000_2000 with word k = 0x1111_1111*k -> wdata sequence 0..0x7777_7777, write=1, transfer=3'b011 then 3'b001 x6 then 3'b101.
REQ-035 SHALL cover ready low for 3 cycles on beat 2 -> beat outputs frozen for 3 cycles, latency 12 cycles.
REQ-036 SHALL cover critical-word-first fill at 0x0000_301C -> addresses 0x301C, 0x3000..0x3018 in order, correct line layout.
REQ-037 SHALL cover rst asserted on beat 4 -> next cycle all outputs 0, no rsp_valid, req_ready=1 after release.
REQ-038 SHALL cover back-to-back requests with req_valid held high -> second accept exactly one cycle after the first rsp_valid.

Source files
------------

// File: rtl/lxs_pkg.sv
// Shared definitions for the line transfer sequencer: FSM states, transfer
// strobe bit positions and beat-count derivation.
package lxs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } lxsState_t;

    localparam int unsigned TR_VALID = 0;
    localparam int unsigned TR_FIRST = 1;
    localparam int unsigned TR_LAST  = 2;

    function automatic int unsigned beatsOf(input int unsigned blockSize);
        return blockSize / 4;
    endfunction

endpackage

// File: rtl/lxs_beat_gen.sv
// Beat counter and word-index/address generator for one cache-line burst.
// Word index wraps inside the line so a burst never leaves its line.
module lxs_beat_gen
    import lxs_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 32,
    localparam int unsigned BEATS = beatsOf(BLOCK_SIZE),
    localparam int unsigned IW    = $clog2(BEATS),
    localparam int unsigned OFFW  = $clog2(BLOCK_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [IW-1:0]    loadIdx,
    input  logic [31-OFFW:0] lineTag,
    output logic [IW-1:0]    widx,
    output logic [31:0]      beatAddr,
    output logic             firstBeat,
    output logic             lastBeat
);

    localparam logic [IW-1:0] LAST_CNT = IW'(BEATS - 1);

    logic [IW-1:0]    beatCnt;
    logic [IW-1:0]    startIdx;
    logic [31-OFFW:0] tagReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            beatCnt  <= '0;
            startIdx <= '0;
            tagReg   <= '0;
        end else if (load) begin
            beatCnt  <= '0;
            startIdx <= loadIdx;
            tagReg   <= lineTag;
        end else if (advance) begin
            beatCnt  <= beatCnt + 1'b1;
        end
    end

    // BEATS is a power of two, so truncating the sum is the modulo wrap.
    always_comb begin
        widx      = startIdx + beatCnt;
        beatAddr  = {tagReg, widx, 2'b00};
        firstBeat = (beatCnt == '0);
        lastBeat  = (beatCnt == LAST_CNT);
    end

endmodule

// File: rtl/line_xfer_sequencer.sv
// Sequences one cache-line fill or write-back as BLOCK_SIZE/4 word beats.
// Optional macro LXS_CRITICAL_WORD_FIRST_EN starts fills at the requested word.
module line_xfer_sequencer
    import lxs_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [BLOCK_SIZE*8-1:0] req_wdata,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [BLOCK_SIZE*8-1:0] rsp_rdata,
    output logic                    busy,
    output logic [31:0]             addr,
    output logic                    write,
    output logic [31:0]             wdata,
    output logic [2:0]              transfer,
    input  logic [31:0]             rdata,
    input  logic                    ready
);

    localparam int unsigned BEATS = beatsOf(BLOCK_SIZE);
    localparam int unsigned IW    = $clog2(BEATS);
    localparam int unsigned OFFW  = $clog2(BLOCK_SIZE);

    lxsState_t state, stateNext;

    logic                    isWrite;
    logic [BLOCK_SIZE*8-1:0] wLine;
    logic [BLOCK_SIZE*8-1:0] rspData;
    logic                    accept;
    logic                    advance;
    logic [IW-1:0]           loadIdx;
    logic [IW-1:0]           widx;
    logic [31:0]             beatAddr;
    logic                    firstBeat;
    logic                    lastBeat;
    logic                    unusedAddrBits;

    assign unusedAddrBits = ^req_addr[OFFW-1:0];

`ifdef LXS_CRITICAL_WORD_FIRST_EN
    assign loadIdx = req_write ? '0 : req_addr[OFFW-1:2];
`else
    assign loadIdx = '0;
`endif

    assign accept  = req_valid && req_ready;
    assign advance = (state == XFER) && ready;

    lxs_beat_gen #(
        .BLOCK_SIZE(BLOCK_SIZE)
    ) beatGen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (advance),
        .loadIdx  (loadIdx),
        .lineTag  (req_addr[31:OFFW]),
        .widx     (widx),
        .beatAddr (beatAddr),
        .firstBeat(firstBeat),
        .lastBeat (lastBeat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isWrite <= 1'b0;
            wLine   <= '0;
            rspData <= '0;
        end else begin
            if (accept) begin
                isWrite <= req_write;
                wLine   <= req_wdata;
            end
            if (advance && !isWrite) begin
                rspData[{widx, 5'b00000} +: 32] <= rdata;
            end
        end
    end

    assign rsp_rdata = rspData;

    // Outputs are gated by rst so the reset cycle itself shows an idle interface.
    always_comb begin
        stateNext = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        addr      = '0;
        write     = 1'b0;
        wdata     = '0;
        transfer  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) stateNext = XFER;
            end
            XFER: begin
                busy               = 1'b1;
                addr               = beatAddr;
                write              = isWrite;
                wdata              = wLine[{widx, 5'b00000} +: 32];
                transfer[TR_VALID] = 1'b1;
                transfer[TR_FIRST] = firstBeat;
                transfer[TR_LAST]  = lastBeat;
                if (ready && lastBeat) stateNext = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (rst) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            busy      = 1'b0;
            addr      = '0;
            write     = 1'b0;
            wdata     = '0;
            transfer  = '0;
        end
    end

endmodule

// File: tb/tb_line_xfer_sequencer.sv
// Directed self-checking bench for line_xfer_sequencer at BLOCK_SIZE=32.
// Adapter model returns rdata = 0xA0 + word + (addr[15:12] << 8).
module tb_line_xfer_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic         req_ready;
    logic         rsp_valid;
    logic [255:0] rsp_rdata;
    logic         busy;
    logic [31:0]  addr;
    logic         write;
    logic [31:0]  wdata;
    logic [2:0]   transfer;
    logic [31:0]  rdata;
    logic         ready;

    int unsigned  vecCount  = 0;
    int unsigned  missCount = 0;
    logic [255:0] lastFill;

    always #5 clk = ~clk;

    line_xfer_sequencer #(
        .BLOCK_SIZE(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .addr     (addr),
        .write    (write),
        .wdata    (wdata),
        .transfer (transfer),
        .rdata    (rdata),
        .ready    (ready)
    );

    always_comb rdata = 32'h0000_00A0 + {29'b0, addr[4:2]} + {20'b0, addr[15:12], 8'b0};

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkVal({tag, ".busy"}, busy, 1'b0);
        checkVal({tag, ".rspValid"}, rsp_valid, 1'b0);
        checkVal({tag, ".addr"}, addr, 32'h0);
        checkVal({tag, ".write"}, write, 1'b0);
        checkVal({tag, ".wdata"}, wdata, 32'h0);
        checkVal({tag, ".transfer"}, transfer, 3'b000);
    endtask

    // Caller leaves the bench at an IDLE cycle, 1 time unit after the edge.
    task automatic doXfer(input string tag, input bit wr, input logic [31:0] a,
                          input logic [255:0] wl, input int stallBeat,
                          input int stallCyc, input bit hold);
        logic [31:0]  base;
        logic [255:0] expLine;
        int           startW;
        int           cycles;
        int           w;
        int           nStall;
        base   = {a[31:5], 5'b0};
        startW = 0;
`ifdef LXS_CRITICAL_WORD_FIRST_EN
        if (!wr) startW = int'(a[4:2]);
`endif
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wl;
        ready     = 1'b1;
        #1;
        checkVal({tag, ".reqReady"}, req_ready, 1'b1);
        tick();
        cycles    = 1;
        req_valid = hold;
        req_write = ~wr;
        req_addr  = ~a;
        req_wdata = ~wl;
        for (int i = 0; i < 8; i++) begin
            w      = (startW + i) % 8;
            nStall = (i == stallBeat) ? stallCyc : 0;
            for (int s = 0; s <= nStall; s++) begin
                ready = (s < nStall) ? 1'b0 : 1'b1;
                #1;
                checkVal($sformatf("%s.b%0d.addr", tag, i), addr, base + 32'(4 * w));
                checkVal($sformatf("%s.b%0d.write", tag, i), write, wr);
                checkVal($sformatf("%s.b%0d.wdata", tag, i), wdata, wl[w*32 +: 32]);
                checkVal($sformatf("%s.b%0d.transfer", tag, i), transfer,
                         {(i == 7), (i == 0), 1'b1});
                checkVal($sformatf("%s.b%0d.reqReady", tag, i), req_ready, 1'b0);
                checkVal($sformatf("%s.b%0d.rspValid", tag, i), rsp_valid, 1'b0);
                tick();
                cycles++;
            end
        end
        ready = 1'b0;
        #1;
        checkVal({tag, ".done.rspValid"}, rsp_valid, 1'b1);
        checkVal({tag, ".done.busy"}, busy, 1'b1);
        checkVal({tag, ".done.reqReady"}, req_ready, 1'b0);
        checkVal({tag, ".done.transfer"}, transfer, 3'b000);
        checkVal({tag, ".done.addr"}, addr, 32'h0);
        checkVal({tag, ".latency"}, 256'(cycles), 256'(9 + stallCyc));
        if (!wr) begin
            for (int k = 0; k < 8; k++)
                expLine[k*32 +: 32] = 32'h0000_00A0 + 32'(k) + {20'b0, a[15:12], 8'b0};
            lastFill = expLine;
        end
        checkVal({tag, ".rspRdata"}, rsp_rdata, lastFill);
        tick();
        ready = 1'b1;
        #1;
        checkVal({tag, ".idle.reqReady"}, req_ready, 1'b1);
        checkVal({tag, ".idle.rspValid"}, rsp_valid, 1'b0);
        checkVal({tag, ".idle.busy"}, busy, 1'b0);
        checkVal({tag, ".idle.rspRdata"}, rsp_rdata, lastFill);
    endtask

    logic [255:0] wbLine;
    logic [255:0] junkLine;

    initial begin
        for (int k = 0; k < 8; k++) wbLine[k*32 +: 32] = 32'h1111_1111 * 32'(k);
        junkLine  = {8{32'hDEAD_BEEF}};
        lastFill  = '0;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = '0;
        ready     = 1'b1;
        tick();
        checkVal("rst.reqReady", req_ready, 1'b0);
        checkIdleOutputs("rst");
        checkVal("rst.rspRdata", rsp_rdata, 256'h0);
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        checkVal("post.reqReady", req_ready, 1'b1);
        checkIdleOutputs("post");

        doXfer("fill1004", 1'b0, 32'h0000_1004, junkLine, -1, 0, 1'b0);
        doXfer("wb2000", 1'b1, 32'h0000_2000, wbLine, -1, 0, 1'b0);
        doXfer("stall", 1'b0, 32'h0000_1000, wbLine, 2, 3, 1'b0);
        doXfer("cwf301c", 1'b0, 32'h0000_301C, junkLine, -1, 0, 1'b0);
        doXfer("b2bA", 1'b1, 32'h0000_5010, wbLine, -1, 0, 1'b1);
        doXfer("b2bB", 1'b0, 32'h0000_6000, junkLine, -1, 0, 1'b0);

        // Abort a fill mid-line with a reset on beat 4.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_1000;
        req_wdata = junkLine;
        ready     = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkVal("abort.beat4.addr", addr, 32'h0000_1010);
        rst = 1'b1;
        #1;
        checkVal("abort.rstcyc.reqReady", req_ready, 1'b0);
        checkIdleOutputs("abort.rstcyc");
        tick();
        rst = 1'b0;
        #1;
        checkVal("abort.after.reqReady", req_ready, 1'b1);
        checkVal("abort.after.rspRdata", rsp_rdata, 256'h0);
        checkIdleOutputs("abort.after");
        for (int i = 0; i < 10; i++) begin
            tick();
            checkVal($sformatf("abort.quiet%0d.rspValid", i), rsp_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
